// File: rtl/engine_alu_ops_controller.sv
// Sequencer that feeds packets one at a time through an external ALU kernel
// and buffers the kernel results in a small output FIFO.
package engine_alu_ops_controller_pkg;
  typedef struct packed {
    logic [1:0]  opcode;
    logic [31:0] operand;
  } ALUOpsConfigurationParameters;

  typedef logic [31:0] MemoryPacketData;
endpackage

module engine_alu_ops_controller
  import engine_alu_ops_controller_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int COUNT_W    = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         start,
  input  ALUOpsConfigurationParameters cfg,
  input  logic [COUNT_W-1:0]           num_packets,
  input  logic                         in_valid,
  input  MemoryPacketData              in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output MemoryPacketData              out_data,
  input  logic                         out_ready,
  output logic                         k_clear,
  output logic                         k_config_params_valid,
  output logic                         k_data_valid,
  output ALUOpsConfigurationParameters k_config_params,
  output MemoryPacketData              k_data,
  input  MemoryPacketData              k_result,
  output logic                         busy,
  output logic                         done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, CLEAR, FETCH, EXEC0, EXEC1, WRITE, DRAIN, DONE
  } state_t;

  state_t                       state;
  logic [COUNT_W-1:0]           remaining;
  ALUOpsConfigurationParameters cfg_q;
  MemoryPacketData              k_data_q;

  MemoryPacketData              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic [CNT_W-1:0]             fifo_count;
  logic                         push;
  logic                         pop;

  assign push = (state == WRITE);
  assign pop  = out_valid && out_ready;

  assign in_ready              = (state == FETCH) && (fifo_count < FIFO_FULL);
  assign k_clear               = (state == CLEAR);
  assign k_data_valid          = (state == EXEC0) || (state == EXEC1);
  assign k_config_params_valid = (state == EXEC0) || (state == EXEC1);
  assign k_config_params       = cfg_q;
  assign k_data                = k_data_q;
  assign busy                  = (state != IDLE);
  assign done                  = (state == DONE);
  assign out_valid             = (fifo_count != '0);
  assign out_data              = fifo_mem[rd_ptr];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      cfg_q     <= '0;
      k_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cfg_q     <= cfg;
            remaining <= num_packets;
            state     <= CLEAR;
          end
        end
        CLEAR: state <= (remaining != '0) ? FETCH : DRAIN;
        FETCH: begin
          // FETCH is only entered with remaining > 0, so this cannot underflow.
          if (in_valid && in_ready) begin
            k_data_q  <= in_data;
            remaining <= remaining - COUNT_W'(1);
            state     <= EXEC0;
          end
        end
        EXEC0: state <= EXEC1;
        EXEC1: state <= WRITE;
        WRITE: state <= (remaining != '0) ? FETCH : DRAIN;
        DRAIN: if (fifo_count == '0) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A packet is only accepted with a free slot and nothing else is in flight,
  // so the WRITE push always has room.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (push) fifo_mem[wr_ptr] <= k_result;
  end

endmodule

// File: tb/tb_engine_alu_ops_controller.sv
// Randomized scoreboard bench for engine_alu_ops_controller with a behavioural
// ALU kernel and an expected-result queue filled at input handshake time.
module tb_engine_alu_ops_controller;
  import engine_alu_ops_controller_pkg::*;

  logic                         ap_clk = 1'b0;
  logic                         ap_rst_n = 1'b0;
  logic                         start = 1'b0;
  ALUOpsConfigurationParameters cfg = '0;
  logic [15:0]                  num_packets = '0;
  logic                         in_valid = 1'b0;
  MemoryPacketData              in_data = '0;
  logic                         in_ready;
  logic                         out_valid;
  MemoryPacketData              out_data;
  logic                         out_ready = 1'b0;
  logic                         k_clear;
  logic                         k_config_params_valid;
  logic                         k_data_valid;
  ALUOpsConfigurationParameters k_config_params;
  MemoryPacketData              k_data;
  MemoryPacketData              k_result;
  logic                         busy;
  logic                         done;

  engine_alu_ops_controller #(.FIFO_DEPTH(4), .COUNT_W(16)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .cfg(cfg),
    .num_packets(num_packets), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .k_clear(k_clear),
    .k_config_params_valid(k_config_params_valid), .k_data_valid(k_data_valid),
    .k_config_params(k_config_params), .k_data(k_data), .k_result(k_result),
    .busy(busy), .done(done)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    MemoryPacketData data;
    int              cyc;
  } exp_t;

  exp_t                         sb[$];
  ALUOpsConfigurationParameters job_cfg = '0;
  int tests = 0, fails = 0;
  int cycle = 0;
  int in_rate = 100, out_rate = 100;
  int accepted = 0, pops = 0;
  int kclear_cnt = 0, done_cnt = 0, busy_cnt = 0, inready_cnt = 0, kdv_cnt = 0;
  int done_cyc = 0, last_pop_cyc = -1;
  bit check_lat = 1'b0;
  bit hold_pending = 1'b0;
  MemoryPacketData hold_data = '0;
  MemoryPacketData kres = '0;

  function automatic MemoryPacketData alu(input ALUOpsConfigurationParameters c,
                                          input MemoryPacketData d);
    case (c.opcode)
      2'd0:    return d + c.operand;
      2'd1:    return d - c.operand;
      2'd2:    return d ^ c.operand;
      default: return d & c.operand;
    endcase
  endfunction

  function automatic ALUOpsConfigurationParameters randCfg();
    ALUOpsConfigurationParameters c;
    c.opcode  = 2'($urandom_range(3));
    c.operand = $urandom;
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  task automatic tick();
    @(negedge ap_clk);
    #1;
  endtask

  // Pulses start; new_job says whether the controller is expected to take it.
  task automatic applyStimulus(input ALUOpsConfigurationParameters c,
                               input int n, input bit new_job);
    tick();
    start       = 1'b1;
    cfg         = c;
    num_packets = 16'(n);
    if (new_job) job_cfg = c;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int d0;
    bit seen;
    d0   = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done_cnt != d0) seen = 1'b1;
    end
    checkOutput(name, 64'(seen), 64'd1);
  endtask

  // Kernel: accumulates nothing, just registers op(cfg, data) while driven.
  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)                               kres <= '0;
    else if (k_clear)                            kres <= '0;
    else if (k_data_valid && k_config_params_valid) kres <= alu(k_config_params, k_data);
  end
  assign k_result = kres;

  always @(posedge ap_clk) cycle <= cycle + 1;

  // Input/output drivers change just after the rising edge.
  initial forever begin
    @(posedge ap_clk);
    #1;
    in_valid  = ($urandom_range(99) < in_rate);
    in_data   = $urandom;
    out_ready = ($urandom_range(99) < out_rate);
  end

  // Monitor: records accepted packets and checks every popped result.
  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back('{alu(job_cfg, in_data), cycle});
        accepted++;
      end
      if (k_clear) kclear_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cycle;
      end
      if (busy) busy_cnt++;
      if (in_ready) inready_cnt++;
      if (k_data_valid) kdv_cnt++;
      if (k_data_valid || k_config_params_valid)
        checkOutput("kvalid_pair", 64'(k_data_valid), 64'(k_config_params_valid));
      if (hold_pending && out_valid)
        checkOutput("out_stable", 64'(out_data), 64'(hold_data));
      if (out_valid && out_ready) begin
        pops++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL sb_underflow: got result %0h expected none at cycle %0d",
                   out_data, cycle);
        end else begin
          e = sb.pop_front();
          checkOutput("result", 64'(out_data), 64'(e.data));
          if (check_lat) begin
            checkOutput("latency", 64'(cycle - e.cyc), 64'd4);
            if (last_pop_cyc >= 0)
              checkOutput("spacing", 64'(cycle - last_pop_cyc), 64'd4);
          end
          last_pop_cyc = cycle;
        end
      end
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
    end else begin
      hold_pending = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a0, c0, b0, i0, d0, k0, p0, n;
    bit hit;

    repeat (3) tick();
    checkOutput("reset_ctrl",
                64'({in_ready, out_valid, done, busy, k_clear, k_data_valid,
                     k_config_params_valid}), 64'd0);
    checkOutput("reset_regs", 64'({k_data, k_config_params}), 64'd0);
    ap_rst_n = 1'b1;
    tick();

    // Three packets at full rate: latency, spacing, single clear, done timing.
    check_lat    = 1'b1;
    last_pop_cyc = -1;
    c0 = kclear_cnt; p0 = pops;
    applyStimulus(randCfg(), 3, 1'b1);
    waitDone("s1_done", 200);
    checkOutput("s1_kclear", 64'(kclear_cnt - c0), 64'd1);
    checkOutput("s1_pops", 64'(pops - p0), 64'd3);
    checkOutput("s1_done_gap", 64'(done_cyc - last_pop_cyc), 64'd2);
    checkOutput("s1_sb_empty", 64'(sb.size()), 64'd0);
    check_lat = 1'b0;

    // Output blocked: exactly FIFO_DEPTH packets fit, then the rest.
    out_rate = 0;
    a0 = accepted;
    applyStimulus(randCfg(), 6, 1'b1);
    repeat (40) tick();
    checkOutput("s2_accepted_full", 64'(accepted - a0), 64'd4);
    checkOutput("s2_in_ready_full", 64'(in_ready), 64'd0);
    checkOutput("s2_busy_full", 64'(busy), 64'd1);
    out_rate = 100;
    waitDone("s2_done", 300);
    checkOutput("s2_accepted", 64'(accepted - a0), 64'd6);
    checkOutput("s2_sb_empty", 64'(sb.size()), 64'd0);

    // Empty job.
    b0 = busy_cnt; i0 = inready_cnt; d0 = done_cnt;
    applyStimulus(randCfg(), 0, 1'b1);
    waitDone("s3_done", 50);
    repeat (3) tick();
    checkOutput("s3_busy_cycles", 64'(busy_cnt - b0), 64'd3);
    checkOutput("s3_in_ready", 64'(inready_cnt - i0), 64'd0);
    checkOutput("s3_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Second start during a job is ignored.
    a0 = accepted;
    applyStimulus(randCfg(), 2, 1'b1);
    repeat (3) tick();
    applyStimulus(randCfg(), 5, 1'b0);
    waitDone("s4_done", 200);
    repeat (3) tick();
    checkOutput("s4_accepted", 64'(accepted - a0), 64'd2);
    checkOutput("s4_sb_empty", 64'(sb.size()), 64'd0);
    checkOutput("s4_idle", 64'(busy), 64'd0);

    // Reset during EXEC1 of the second packet of five.
    k0 = kdv_cnt;
    hit = 1'b0;
    applyStimulus(randCfg(), 5, 1'b1);
    for (int i = 0; i < 100 && !hit; i++) begin
      if (kdv_cnt - k0 >= 4) hit = 1'b1;
      else tick();
    end
    checkOutput("s5_reached_exec1", 64'(hit), 64'd1);
    ap_rst_n = 1'b0;
    #1;
    checkOutput("s5_reset_ctrl",
                64'({in_ready, out_valid, done, busy, k_clear, k_data_valid,
                     k_config_params_valid}), 64'd0);
    checkOutput("s5_reset_regs", 64'({k_data, k_config_params}), 64'd0);
    sb.delete();
    d0 = done_cnt;
    repeat (2) tick();
    ap_rst_n = 1'b1;
    repeat (20) tick();
    checkOutput("s5_no_done", 64'(done_cnt - d0), 64'd0);
    checkOutput("s5_idle", 64'(busy), 64'd0);
    a0 = accepted;
    applyStimulus(randCfg(), 1, 1'b1);
    waitDone("s5_done", 100);
    checkOutput("s5_accepted", 64'(accepted - a0), 64'd1);
    checkOutput("s5_sb_empty", 64'(sb.size()), 64'd0);

    // Random jobs with random back-pressure on both sides.
    for (int j = 0; j < 12; j++) begin
      in_rate  = int'($urandom_range(100, 30));
      out_rate = int'($urandom_range(100, 30));
      n        = int'($urandom_range(10, 1));
      a0       = accepted;
      applyStimulus(randCfg(), n, 1'b1);
      waitDone("rnd_done", 2000);
      checkOutput("rnd_accepted", 64'(accepted - a0), 64'(n));
      checkOutput("rnd_sb_empty", 64'(sb.size()), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/engine_alu_ops_controller.md
ENGINE_ALU_OPS_CONTROLLER -- requirements
Module: engine_alu_ops_controller

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, power of two >= 2: depth of result output FIFO.
REQ-002 SHALL have parameter COUNT_W, default 16: width of packet-count register.
REQ-003 SHALL have port ap_clk  input  1  sole clock; all state rises on posedge.
REQ-004 SHALL have port ap_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse; latches cfg and num_packets, begins a job.
REQ-006 SHALL have port cfg  input  ALUOpsConfigurationParameters  job configuration.
REQ-007 SHALL have port num_packets  input  COUNT_W  packets to process in the job.
REQ-008 SHALL have ports in_valid input 1, in_data input MemoryPacketData, in_ready output 1: packet stream in.
REQ-009 SHALL have ports out_valid output 1, out_data output MemoryPacketData, out_ready input 1: result stream out.
REQ-010 SHALL have ports k_clear, k_config_params_valid, k_data_valid output 1 each; k_config_params output ALUOpsConfigurationParameters; k_data output MemoryPacketData: ALU kernel drive.
REQ-011 SHALL have port k_result  input  MemoryPacketData  ALU kernel result.
REQ-012 SHALL have ports busy output 1 (state != IDLE) and done output 1 (one-cycle job-complete pulse).

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, FETCH, EXEC0, EXEC1, WRITE, DRAIN, DONE.
REQ-014 IDLE: start=1 -> latch cfg and num_packets into remaining, go CLEAR; start outside IDLE SHALL be ignored.
REQ-015 CLEAR: k_clear=1 for exactly one cycle; next FETCH if remaining>0, else DRAIN.
REQ-016 FETCH: in_ready=1 iff fifo_count<FIFO_DEPTH; on in_valid&&in_ready latch in_data into k_data register, decrement remaining, go EXEC0.
REQ-017 EXEC0, EXEC1: k_data_valid=1 and k_config_params_valid=1; k_data and k_config_params stable across both cycles.
REQ-018 WRITE: push k_result into FIFO; next FETCH if remaining>0, else DRAIN.
REQ-019 k_data_valid and k_config_params_valid SHALL be 0 in every state other than EXEC0/EXEC1.
REQ-020 Latency: handshake in cycle t -> push at end of t+3 -> out_valid visible in t+4 when FIFO previously empty.
REQ-021 Throughput: at most one packet per 4 cycles; at most one packet in flight.
REQ-022 FIFO gating in FETCH SHALL guarantee WRITE never finds FIFO full; push on full SHALL never occur.
REQ-023 FIFO: out_valid = (fifo_count>0); pop on out_valid&&out_ready; out_data = head entry; simultaneous push and pop leaves count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-024 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 DRAIN: wait until fifo_count==0, then DONE.
REQ-026 DONE: done=1 for one cycle, return IDLE; busy=0 only in IDLE.
REQ-027 remaining SHALL never underflow; num_packets=0 SHALL run CLEAR->DRAIN->DONE without in_ready ever asserting.
REQ-028 FIFO output draining SHALL continue in every state, including IDLE.

Reset
REQ-029 ap_rst_n=0 SHALL asynchronously force state IDLE, remaining=0, FIFO pointers and count 0, latched cfg and k_data 0.
REQ-030 During reset: in_ready, out_valid, done, busy, k_clear, k_data_valid, k_config_params_valid SHALL be 0.
REQ-031 Reset mid-job SHALL discard in-flight packet and FIFO contents; no done pulse follows.

Verification
REQ-032 num_packets=3, in_valid=1, out_ready=1 -> k_clear one cycle, 3 results out at 4-cycle spacing, done one cycle after FIFO empties.
REQ-033 num_packets=6, out_ready=0 -> exactly 4 packets accepted, in_ready=0 while full; out_ready=1 -> remaining 2 accepted, 6 results in order, done.
REQ-034 num_packets=0 -> busy 3 cycles (CLEAR, DRAIN, DONE), done pulses, in_ready stays 0.
REQ-035 start pulsed while busy -> ignored; remaining and cfg unchanged.
REQ-036 ap_rst_n=0 during EXEC1 of packet 2 of 5 -> all outputs 0 immediately; after release, new job of 1 packet completes normally.
REQ-037 Simultaneous push and pop with fifo_count=2 -> count stays 2, order preserved across pointer wrap.
